stream_mux_rr: RTL and testbench

Parametrised N-channel, W-bit registered stream multiplexer with enable, valid/ready handshaking on every port and two selection modes: fixed select (classic mux) and round-robin arbitration. It replaces the combinational 4:1 enable mux wherever several producers share one consumer, such as a shared output bus or a shared processing stage. The output is registered: one beat in flight, full throughput.

---
 rtl/stream_mux_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/stream_mux_rr.sv | 87 ++++++++
 tb/tb_stream_mux_rr.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: mode encodings
// and the wrap-around index helper used by the arbiter search.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Next channel index after idx, wrapping modulo n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found after
// ptr, searching ptr+1, ptr+2, ... with wrap-around.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx,
  output logic            any
);

  int  idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = |req;
    found     = 1'b0;
    idx       = int'(ptr);
    for (int k = 0; k < N; k++) begin
      idx = rr_next(idx, N);
      if (!found && req[idx[SELW-1:0]]) begin
        found                  = 1'b1;
        grant[idx[SELW-1:0]]   = 1'b1;
        grant_idx              = idx[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with fixed-select and round-robin modes;
// one output beat in flight, full throughput when the consumer is ready.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  input  logic            out_ready
);

  // Handshake: a beat moves on a port in any cycle where valid and ready are
  // both high at the rising edge. Producers hold valid/data until ready; the
  // output register never looks at out_ready combinationally, and in_ready
  // sees in_valid only through the arbiter in round-robin mode.

  logic [SELW-1:0] ptr;
  logic [N-1:0]    rr_grant;
  logic [SELW-1:0] rr_idx;
  logic            rr_any;
  logic            space;
  logic            sel_ok;
  logic            accept;
  logic [SELW-1:0] g;
  logic [W-1:0]    g_data;

  rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any       (rr_any)
  );

  assign space  = !out_valid || out_ready;
  assign sel_ok = (int'(sel) < N);
  assign g      = (mode == MODE_RR) ? rr_idx : sel;
  assign accept = |(in_valid & in_ready);

  always_comb begin
    in_ready = '0;
    // Nothing is accepted while reset is held, even if the output is empty.
    if (!rst && en && space) begin
      if (mode == MODE_FIXED) begin
        if (sel_ok) in_ready[sel] = 1'b1;
      end else if (rr_any) begin
        in_ready = rr_grant;
      end
    end
  end

  always_comb begin
    g_data = '0;
    for (int i = 0; i < N; i++) begin
      if (i == int'(g)) g_data = in_data[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SELW'(N - 1);
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_chan  <= g;
      if (mode == MODE_RR) ptr <= g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (N=4, W=8): the driver pushes expected
// {chan,data} beats, a negedge monitor pops and compares delivered beats.
module tb_stream_mux_rr;

  localparam int N = 4;
  localparam int W = 8;
  localparam int SELW = 2;

  logic            clk;
  logic            rst;
  logic            en;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_chan;
  logic            out_ready;

  logic [SELW+W-1:0] exp_q[$];
  int total;
  int bad;

  stream_mux_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] dat(input int c);
    logic [W-1:0] t[4];
    t[0] = 8'h11; t[1] = 8'h22; t[2] = 8'hA5; t[3] = 8'h3C;
    return t[c];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Set inputs just after a rising edge, then let combinational outputs settle.
  task automatic drive(input logic e, input logic m, input logic [SELW-1:0] s,
                       input logic [N-1:0] v, input logic o);
    @(posedge clk);
    #1;
    en = e; mode = m; sel = s; in_valid = v; out_ready = o;
    #1;
  endtask

  task automatic expect_beat(input int c);
    exp_q.push_back({SELW'(c), dat(c)});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat: unexpected chan=%0d data=%0h at %0t", out_chan, out_data, $time);
      end else begin
        logic [SELW+W-1:0] e;
        e = exp_q.pop_front();
        if ({out_chan, out_data} !== e) begin
          bad++;
          $display("FAIL beat: got chan=%0d data=%0h expected chan=%0d data=%0h at %0t",
                   out_chan, out_data, e[SELW+W-1:W], e[W-1:0], $time);
        end
      end
    end
  end

  initial begin
    int rr_seq[8];
    int skip_seq[7];
    total = 0; bad = 0;
    rst = 1'b1; en = 1'b1; mode = 1'b1; sel = '0; in_valid = 4'hF; out_ready = 1'b1;
    in_data = {dat(3), dat(2), dat(1), dat(0)};

    // reset held two cycles with every channel valid
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_chan", 32'(out_chan), 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // round-robin, all valid: 0,1,2,3,0,1,2,3
    rr_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) drive(1'b1, 1'b1, 2'd0, 4'hF, 1'b1);
      chk("rr_all_in_ready", 32'(in_ready), 32'(1) << rr_seq[i]);
      expect_beat(rr_seq[i]);
    end

    // fixed select: sel=2 then sel=0, independent of the RR pointer
    drive(1'b1, 1'b0, 2'd2, 4'hF, 1'b1);
    chk("fixed_sel2_in_ready", 32'(in_ready), 32'h4);
    expect_beat(2);
    drive(1'b1, 1'b0, 2'd0, 4'hF, 1'b1);
    chk("fixed_sel0_in_ready", 32'(in_ready), 32'h1);
    expect_beat(0);

    // RR skipping: channels 1,3 then only 3
    skip_seq = '{1, 3, 1, 3, 3, 3, 3};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 2'd0, (i < 4) ? 4'b1010 : 4'b1000, 1'b1);
      chk("rr_skip_in_ready", 32'(in_ready), 32'(1) << skip_seq[i]);
      expect_beat(skip_seq[i]);
    end

    // backpressure while holding 3C
    drive(1'b1, 1'b0, 2'd3, 4'b1000, 1'b1);
    chk("bp_accept_in_ready", 32'(in_ready), 32'h8);
    expect_beat(3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 2'd3, 4'b1000, 1'b0);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_out_data", 32'(out_data), 32'h3C);
      chk("bp_out_valid", 32'(out_valid), 32'h1);
    end
    drive(1'b1, 1'b0, 2'd3, 4'b1000, 1'b1);
    chk("bp_release_in_ready", 32'(in_ready), 32'h8);
    expect_beat(3);
    drive(1'b1, 1'b0, 2'd3, 4'b0000, 1'b1);
    drive(1'b1, 1'b0, 2'd3, 4'b0000, 1'b1);
    chk("bp_drained_out_valid", 32'(out_valid), 32'h0);

    // enable low: no accepts, held beat drains (ptr=3 so RR grants 0)
    drive(1'b1, 1'b1, 2'd0, 4'hF, 1'b1);
    chk("en_accept_in_ready", 32'(in_ready), 32'h1);
    expect_beat(0);
    drive(1'b0, 1'b1, 2'd0, 4'hF, 1'b1);
    chk("en_low_in_ready", 32'(in_ready), 32'h0);
    chk("en_low_out_valid", 32'(out_valid), 32'h1);
    drive(1'b0, 1'b1, 2'd0, 4'hF, 1'b1);
    chk("en_low_drained", 32'(out_valid), 32'h0);

    // reset with a held beat: beat dropped, pointer back to N-1
    drive(1'b1, 1'b1, 2'd0, 4'hF, 1'b0);
    chk("mid_accept_in_ready", 32'(in_ready), 32'h2);
    @(posedge clk); #1;
    chk("mid_held_valid", 32'(out_valid), 32'h1);
    chk("mid_held_chan", 32'(out_chan), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    expect_beat(0);
    drive(1'b1, 1'b1, 2'd0, 4'hF, 1'b1);
    chk("post_rst_next_in_ready", 32'(in_ready), 32'h2);
    expect_beat(1);
    drive(1'b1, 1'b1, 2'd0, 4'h0, 1'b1);
    drive(1'b1, 1'b1, 2'd0, 4'h0, 1'b1);
    drive(1'b1, 1'b1, 2'd0, 4'h0, 1'b1);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
